// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared BCD constants, 7-segment patterns and the per-decade next-state helper.
package bcd_disp_pkg;
    localparam logic [3:0] BCD_MAX = 4'd9;
    // {g,f,e,d,c,b,a} active-high, index 15 first: F E d C b A 9..0
    localparam logic [15:0][6:0] SEG7 = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77,
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    function automatic logic [4:0] bcd_next(input logic [3:0] digit, input logic up, input logic down);
        return up   ? ((digit >= BCD_MAX) ? {4'd0, 1'b1} : {digit + 4'd1, 1'b0}) :
               down ? ((digit == 4'd0) ? {BCD_MAX, 1'b1} : {digit - 4'd1, 1'b0}) :
                      {digit, 1'b0};
    endfunction
endpackage

// File: rtl/bcd_updown_display_if.sv
// bcd_updown_display_if: control strobes in, count/status and display drive out.
interface bcd_updown_display_if #(parameter int DIGITS = 3);
    logic                  inc;
    logic                  dec;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  scan_tick;
    logic [4*DIGITS-1:0]   count;
    logic                  carry_out;
    logic                  borrow_out;
    logic [DIGITS-1:0]     dig_sel;
    logic [6:0]            seg;
    modport master (output inc, dec, load, load_val, scan_tick,
                    input  count, carry_out, borrow_out, dig_sel, seg);
    modport slave  (input  inc, dec, load, load_val, scan_tick,
                    output count, carry_out, borrow_out, dig_sel, seg);
endinterface

// File: rtl/bcd_digit.sv
// bcd_digit: one decade register; term flags the ripple condition for the next decade.
module bcd_digit import bcd_disp_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       down,
    input  logic       load,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       term
);
    logic [3:0] r_q;
    logic [4:0] w_nxt;
    assign w_nxt = bcd_next(r_q, up, down);
    assign term  = w_nxt[0];
    assign q     = r_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_q <= '0;
        else if (load)
            r_q <= (d > BCD_MAX) ? 4'd0 : d;
        else if (en)
            r_q <= w_nxt[4:1];
    end
endmodule

// File: rtl/bcd_updown_display.sv
// bcd_updown_display: N-decade up/down BCD counter with multiplexed 7-segment scanner.
module bcd_updown_display import bcd_disp_pkg::*; #(
    parameter int DIGITS         = 3,
    parameter int WRAP           = 1,
    parameter int LZ_BLANK       = 0,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input logic                  clk,
    input logic                  rst,
    bcd_updown_display_if.slave  bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    logic                w_up;
    logic                w_dn;
    logic                w_all;
    logic                w_act;
    logic                w_hot;
    logic                w_blank;
    logic [3:0]          w_dig;
    logic [6:0]          w_seg;
    logic [4*DIGITS-1:0] w_count;
    logic [DIGITS-1:0]   w_term;
    logic [DIGITS-1:0]   w_en;
    logic [DIGITS-1:0]   w_hz;
    logic [DIGITS-1:0]   r_sel;
    logic [IW-1:0]       r_idx;
    logic                r_carry;
    logic                r_borrow;
    assign w_up  = bus.inc & ~bus.dec & ~bus.load;
    assign w_dn  = bus.dec & ~bus.inc & ~bus.load;
    assign w_all = &w_term;
    // in saturate mode a full ripple means the counter is pinned, so nothing moves
    assign w_act = (w_up | w_dn) & ((WRAP != 0) | ~w_all);
    always_comb begin
        logic w_run;
        logic w_z;
        w_run = w_act;
        for (int k = 0; k < DIGITS; k++) begin
            w_en[k] = w_run;
            w_run   = w_run & w_term[k];
        end
        w_z = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_z     = w_z & (w_count[4*k +: 4] == 4'd0);
            w_hz[k] = w_z;
        end
    end
    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_dig
            bcd_digit u_dig (
                .clk  (clk),
                .rst  (rst),
                .en   (w_en[i]),
                .up   (w_up),
                .down (w_dn),
                .load (bus.load),
                .d    (bus.load_val[4*i +: 4]),
                .q    (w_count[4*i +: 4]),
                .term (w_term[i])
            );
        end
    endgenerate
    assign w_hot = (r_sel != '0) && ((r_sel & (r_sel - 1'b1)) == '0);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_sel    <= DIGITS'(1);
            r_idx    <= '0;
        end else begin
            r_carry  <= (WRAP != 0) && w_up && w_all;
            r_borrow <= (WRAP != 0) && w_dn && w_all;
            if (bus.scan_tick) begin
                r_sel <= w_hot ? ((r_sel << 1) | (r_sel >> (DIGITS - 1))) : DIGITS'(1);
                r_idx <= (!w_hot || r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end
        end
    end
    always_comb begin
        w_dig   = w_count[4*r_idx +: 4];
        w_blank = (LZ_BLANK != 0) && (r_idx != '0) && w_hz[r_idx];
        w_seg   = w_blank ? 7'd0 : SEG7[w_dig];
    end
    assign bus.count      = w_count;
    assign bus.carry_out  = r_carry;
    assign bus.borrow_out = r_borrow;
    assign bus.dig_sel    = (SEL_ACTIVE_LOW != 0) ? ~r_sel : r_sel;
    assign bus.seg        = (SEG_ACTIVE_LOW != 0) ? ~w_seg : w_seg;
endmodule

// File: tb/tb_bcd_updown_display.sv
// tb_bcd_updown_display: scoreboard bench over a wrapping/blanking unit and a saturating inverted-polarity unit.
module tb_bcd_updown_display;
    typedef struct {
        int          id;
        int          d;
        logic [11:0] c;
        logic        cy;
        logic        bo;
        logic [2:0]  sel;
        logic [6:0]  seg;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    int   stp = 0;
    exp_t sb[$];
    bcd_updown_display_if #(.DIGITS(3)) if0 ();
    bcd_updown_display_if #(.DIGITS(3)) if1 ();
    bcd_updown_display #(.DIGITS(3), .WRAP(1), .LZ_BLANK(1), .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    bcd_updown_display #(.DIGITS(3), .WRAP(0), .LZ_BLANK(1), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    always #5 clk = ~clk;
    task automatic push(input int d, input logic [11:0] c, input logic cy, input logic bo,
                        input logic [2:0] sel, input logic [6:0] seg);
        exp_t e;
        e.id = stp; e.d = d; e.c = c; e.cy = cy; e.bo = bo; e.sel = sel; e.seg = seg;
        sb.push_back(e);
        stp++;
    endtask
    task automatic step(input int d, input logic ld, input logic up, input logic dn, input logic tk,
                        input logic [11:0] lv, input logic [11:0] c, input logic cy, input logic bo,
                        input logic [2:0] sel, input logic [6:0] seg);
        @(negedge clk);
        if0.load = (d == 0) & ld; if0.inc = (d == 0) & up; if0.dec = (d == 0) & dn;
        if0.scan_tick = (d == 0) & tk; if0.load_val = (d == 0) ? lv : 12'h0;
        if1.load = (d == 1) & ld; if1.inc = (d == 1) & up; if1.dec = (d == 1) & dn;
        if1.scan_tick = (d == 1) & tk; if1.load_val = (d == 1) ? lv : 12'h0;
        push(d, c, cy, bo, sel, seg);
    endtask
    // monitor: outputs settle after every clock edge or async reset edge
    initial begin
        exp_t e;
        logic [11:0] c;
        logic cy, bo;
        logic [2:0] sel;
        logic [6:0] seg;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (sb.size() != 0) begin
                e   = sb.pop_front();
                c   = (e.d == 0) ? if0.count      : if1.count;
                cy  = (e.d == 0) ? if0.carry_out  : if1.carry_out;
                bo  = (e.d == 0) ? if0.borrow_out : if1.borrow_out;
                sel = (e.d == 0) ? if0.dig_sel    : if1.dig_sel;
                seg = (e.d == 0) ? if0.seg        : if1.seg;
                n_chk++;
                if (c === e.c && cy === e.cy && bo === e.bo && sel === e.sel && seg === e.seg)
                    n_pass++;
                else
                    $display("FAIL step%0d dut%0d: got count=%h cy=%b bo=%b sel=%b seg=%h, want count=%h cy=%b bo=%b sel=%b seg=%h",
                             e.id, e.d, c, cy, bo, sel, seg, e.c, e.cy, e.bo, e.sel, e.seg);
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        {if0.load, if0.inc, if0.dec, if0.scan_tick, if0.load_val} = '0;
        {if1.load, if1.inc, if1.dec, if1.scan_tick, if1.load_val} = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        //   d ld up dn tk load_val  count  cy bo sel     seg
        step(0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 3'b001, 7'h3F);
        step(0, 1, 0, 0, 0, 12'h998, 12'h998, 0, 0, 3'b001, 7'h7F);
        step(0, 0, 1, 0, 0, 12'h000, 12'h999, 0, 0, 3'b001, 7'h6F);
        step(0, 0, 1, 0, 0, 12'h000, 12'h000, 1, 0, 3'b001, 7'h3F);
        step(0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 3'b001, 7'h3F);
        step(0, 0, 0, 1, 0, 12'h000, 12'h999, 0, 1, 3'b001, 7'h6F);
        step(0, 0, 0, 0, 0, 12'h000, 12'h999, 0, 0, 3'b001, 7'h6F);
        step(0, 1, 1, 1, 0, 12'h456, 12'h456, 0, 0, 3'b001, 7'h7D);
        step(0, 0, 1, 1, 0, 12'h000, 12'h456, 0, 0, 3'b001, 7'h7D);
        step(0, 1, 0, 0, 0, 12'h3C7, 12'h307, 0, 0, 3'b001, 7'h07);
        step(0, 1, 0, 0, 0, 12'h120, 12'h120, 0, 0, 3'b001, 7'h3F);
        step(0, 0, 0, 0, 1, 12'h000, 12'h120, 0, 0, 3'b010, 7'h5B);
        step(0, 0, 0, 0, 1, 12'h000, 12'h120, 0, 0, 3'b100, 7'h06);
        step(0, 0, 0, 0, 1, 12'h000, 12'h120, 0, 0, 3'b001, 7'h3F);
        step(0, 1, 0, 0, 0, 12'h007, 12'h007, 0, 0, 3'b001, 7'h07);
        step(0, 0, 0, 0, 1, 12'h000, 12'h007, 0, 0, 3'b010, 7'h00);
        step(0, 0, 0, 0, 1, 12'h000, 12'h007, 0, 0, 3'b100, 7'h00);
        step(0, 0, 0, 0, 1, 12'h000, 12'h007, 0, 0, 3'b001, 7'h07);
        step(0, 1, 0, 0, 0, 12'h099, 12'h099, 0, 0, 3'b001, 7'h6F);
        step(0, 0, 1, 0, 0, 12'h000, 12'h100, 0, 0, 3'b001, 7'h3F);
        step(0, 0, 0, 1, 0, 12'h000, 12'h099, 0, 0, 3'b001, 7'h6F);
        step(0, 0, 1, 0, 0, 12'h000, 12'h100, 0, 0, 3'b001, 7'h3F);
        step(0, 0, 1, 0, 0, 12'h000, 12'h101, 0, 0, 3'b001, 7'h06);
        step(0, 0, 0, 0, 1, 12'h000, 12'h101, 0, 0, 3'b010, 7'h3F);
        step(0, 1, 0, 0, 0, 12'h999, 12'h999, 0, 0, 3'b010, 7'h6F);
        step(0, 0, 1, 0, 0, 12'h000, 12'h000, 1, 0, 3'b010, 7'h00);
        // async reset in mid-cycle while carry is high and the scan sits on digit 1
        @(negedge clk);
        {if0.load, if0.inc, if0.dec, if0.scan_tick, if0.load_val} = '0;
        #2;
        push(0, 12'h000, 0, 0, 3'b001, 7'h3F);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 3'b110, 7'h40);
        step(1, 0, 0, 1, 0, 12'h000, 12'h000, 0, 0, 3'b110, 7'h40);
        step(1, 1, 0, 0, 0, 12'h999, 12'h999, 0, 0, 3'b110, 7'h10);
        step(1, 0, 1, 0, 0, 12'h000, 12'h999, 0, 0, 3'b110, 7'h10);
        step(1, 1, 0, 0, 0, 12'h007, 12'h007, 0, 0, 3'b110, 7'h78);
        step(1, 0, 0, 0, 1, 12'h000, 12'h007, 0, 0, 3'b101, 7'h7F);
        step(1, 0, 0, 0, 1, 12'h000, 12'h007, 0, 0, 3'b011, 7'h7F);
        step(1, 0, 0, 0, 1, 12'h000, 12'h007, 0, 0, 3'b110, 7'h78);
        @(negedge clk);
        {if1.load, if1.inc, if1.dec, if1.scan_tick, if1.load_val} = '0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (sb.size() == 0)
            n_pass++;
        else
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bcd_updown_display.md
Name: bcd_updown_display

Overview:
- Parametrised N-digit synchronous up/down BCD counter with integrated multiplexed 7-segment scanner.
- Successor to the discrete ripple-chain decade counters: a single clock domain, real count-down, parallel load, wrap/saturate mode and leading-zero blanking.
- Sits between the button/prescaler logic and the display header pins. It replaces chained per-digit counters plus a separate digit-select ring and decoder.

Parameters:
- DIGITS, 3, number of BCD decades (1..8).
- WRAP, 1, 1 = wrap at max/zero; 0 = saturate at 9..9 / 0..0.
- LZ_BLANK, 0, 1 = blank leading zero digits (digit 0 is never blanked).
- SEG_ACTIVE_LOW, 0, 1 = invert seg output polarity.
- SEL_ACTIVE_LOW, 0, 1 = invert dig_sel output polarity.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- inc, in, 1, count-up strobe (sampled each clk when high).
- dec, in, 1, count-down strobe.
- load, in, 1, parallel load strobe.
- load_val, in, 4*DIGITS, BCD load value (digit i at bits 4i+3:4i).
- scan_tick, in, 1, advance the display digit (one-cycle enable from the prescaler).
- count, out, 4*DIGITS, current BCD value.
- carry_out, out, 1, one-cycle pulse on up-wrap.
- borrow_out, out, 1, one-cycle pulse on down-wrap.
- dig_sel, out, DIGITS, one-hot digit enable.
- seg, out, 7, segments {g,f,e,d,c,b,a}.

Behaviour:
- Reset (async, rst=1): count=0, carry_out=0, borrow_out=0, dig_sel=one-hot bit0, scan index=0. Outputs hold these values until the first clk edge after rst deasserts.
- Priority each clk edge: load > (inc xor dec) > hold.
- inc and dec both high: no change, no pulses.
- load: count<=load_val next cycle. A digit nibble >9 is forced to 0 on load.
- Up: standard BCD ripple inside one cycle. Digit i increments when all lower digits are 9, and wraps 9->0.
- Up from 9..9:
  - WRAP=1: count<=0 and carry_out=1 for exactly one cycle.
  - WRAP=0: count holds at 9..9 and carry_out stays 0.
- Down: digit i decrements when all lower digits are 0, and wraps 0->9.
- Down from 0..0:
  - WRAP=1: count<=9..9 and borrow_out=1 for one cycle.
  - WRAP=0: count holds and borrow_out stays 0.
- Latency: count, carry_out and borrow_out are registered and valid the cycle after the strobe. Strobes on consecutive cycles each take effect.
- Scanner:
  - On scan_tick, dig_sel rotates bit i -> bit i+1, and bit DIGITS-1 -> bit 0.
  - An illegal (non-one-hot) state recovers to bit0 on the next tick.
- seg is combinational from count digit[scan index] through the hex decoder:
  - 0-9 as digits, A-F retained for load debug.
  - Active-high patterns: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Polarity per SEG_ACTIVE_LOW.
- Leading-zero blanking (LZ_BLANK=1): a digit shows all-off when it and every higher digit are 0, except digit 0. Example: 007 shows as blank, blank, 7.
- Reset mid-count or mid-scan: immediate return to reset values. No pulse is emitted on reset.

Decomposition:
- Package bcd_disp_pkg holds:
  - seg7 pattern constants (16 entries).
  - BCD_MAX=4'd9.
  - a function bcd_next(digit, up, down) returning {next_digit, ripple}.
- One sub-module, bcd_digit: a single decade register with en, up, down, load, d inputs and q, term (q==9 when up / q==0 when down) outputs. It is instantiated DIGITS times. Enables chain combinationally, so the whole counter is synchronous.
- Scanner and decoder stay in the top module.

Test Plan:
- Reset: assert rst mid-operation -> count=000, dig_sel=001, carry_out=0 asynchronously, before any clk edge.
- Up wrap (DIGITS=3, WRAP=1): load 998, two inc pulses -> 999 then 000, carry_out high exactly on the 000 cycle.
- Down wrap and saturate:
  - WRAP=1: dec at 000 -> 999 with borrow_out one cycle.
  - WRAP=0: dec at 000 -> stays 000, no borrow.
  - WRAP=0: inc at 999 -> stays 999.
- Priority: load=1, load_val=456 with inc=dec=1 -> 456. Next cycle inc=dec=1 -> still 456. Load nibble 4'hC -> digit becomes 0.
- Scan: count=120, LZ_BLANK=1, DIGITS=3. Three scan_ticks -> dig_sel 001->010->100->001, with seg = "0", "2", "1" patterns in that order.
- Blanking: count=007, LZ_BLANK=1 -> digits 2 and 1 seg=0000000 (active-high), digit 0 = 0000111. With SEG_ACTIVE_LOW=1 the same patterns appear inverted.
